// File: rtl/fir_feeder_pkg.sv
// fir_feeder_pkg: shared types and constants for the FIR feeder block.
//   state_e     - sequencer states
//   NUM_COEFF   - coefficient bank entries
//   COEFF_IDX_W - bank index width
//   DATA_W      - sample / coefficient / result width
package fir_feeder_pkg;
  localparam int NUM_COEFF   = 4;
  localparam int COEFF_IDX_W = 2;
  localparam int DATA_W      = 16;

  typedef enum logic [2:0] {
    IDLE, C_REQ, C_WAIT, S_REQ, S_WAIT, CAPTURE
  } state_e;
endpackage

// File: rtl/fir_feeder_if.sv
// fir_feeder_if: feeder <-> FIR filter handshake bundle.
//   data_ready, load_coeff, sample_data, fir_coefficient : feeder -> filter
//   modwait, fir_out, err                                 : filter -> feeder
// master = feeder side, slave = filter side.
interface fir_feeder_if;
  import fir_feeder_pkg::*;
  logic              data_ready;
  logic              load_coeff;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] fir_coefficient;
  logic              modwait;
  logic [DATA_W-1:0] fir_out;
  logic              err;

  modport master (output data_ready, load_coeff, sample_data, fir_coefficient,
                  input  modwait, fir_out, err);
  modport slave  (input  data_ready, load_coeff, sample_data, fir_coefficient,
                  output modwait, fir_out, err);
endinterface

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: host sample buffer, registered storage plus occupancy count.
//   clk, n_rst        - clock, async active-low reset
//   push_i, wdata_i   - write request (ignored when full)
//   pop_i             - read request (ignored when empty)
//   rdata_o           - head entry (valid while !empty_o)
//   full_o, empty_o   - occupancy flags
module fir_sample_fifo
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fir_feeder.sv
// fir_feeder: initiator for the FIR filter sample/coefficient interface.
//   clk, n_rst                        - clock, async active-low reset
//   coeff_wr/coeff_idx/coeff_wdata    - host bank write (dropped while coeff_busy)
//   coeff_start, coeff_busy           - request/status of a 4-coefficient load
//   sample_valid/sample_in/sample_ready - host sample push into the FIFO
//   fir (fir_feeder_if.master)        - filter handshake
//   result_valid/result_data/result_err - one-cycle result pulse
//   timeout                           - sticky watchdog flag
// Build option: FEEDER_TIMEOUT_EN enables the request watchdog (TIMEOUT_CYC).
module fir_feeder
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   coeff_wr,
  input  logic [COEFF_IDX_W-1:0] coeff_idx,
  input  logic [DATA_W-1:0]      coeff_wdata,
  input  logic                   coeff_start,
  output logic                   coeff_busy,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_in,
  output logic                   sample_ready,
  fir_feeder_if.master           fir,
  output logic                   result_valid,
  output logic [DATA_W-1:0]      result_data,
  output logic                   result_err,
  output logic                   timeout
);
  state_e                 state_q, state_d;
  logic [COEFF_IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [DATA_W-1:0]      bank_q [NUM_COEFF];
  logic [DATA_W-1:0]      sdata_q, sdata_d, coef_q, coef_d, res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   pending_q, pend_clr, rdy_q, timeout_q, to_hit, to_expired;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]      fifo_rdata;

  // rdy_q keeps sample_ready low while reset is held.
  assign sample_ready = rdy_q & ~fifo_full;
  assign fifo_push    = sample_valid & sample_ready;

  fir_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (fifo_push),
    .wdata_i (sample_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;

  // Counts cycles spent in the current REQ state; any state change restarts it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tcnt_q <= '0;
    else if ((state_d != state_q) || !(state_q inside {C_REQ, S_REQ})) tcnt_q <= '0;
    else tcnt_q <= tcnt_q + 1'b1;
  end
  assign to_expired = (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: REQ states wait for modwait indefinitely.
  assign to_expired = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sdata_d    = sdata_q;
    coef_d     = coef_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    fifo_pop   = 1'b0;
    pend_clr   = 1'b0;
    to_hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = C_REQ;
          idx_d   = '0;
          coef_d  = bank_q[0];
        end else if (!fifo_empty) begin
          state_d  = S_REQ;
          fifo_pop = 1'b1;
          sdata_d  = fifo_rdata;
        end
      end
      C_REQ: begin
        if (fir.modwait) state_d = C_WAIT;
        else if (to_expired) begin
          state_d  = IDLE;
          pend_clr = 1'b1;
          to_hit   = 1'b1;
        end
      end
      C_WAIT: begin
        if (!fir.modwait) begin
          if (idx_q == COEFF_IDX_W'(NUM_COEFF - 1)) begin
            state_d  = IDLE;
            pend_clr = 1'b1;
          end else begin
            state_d = C_REQ;
            idx_d   = idx_nxt;
            coef_d  = bank_q[idx_nxt];
          end
        end
      end
      S_REQ: begin
        if (fir.modwait) state_d = S_WAIT;
        else if (to_expired) begin
          state_d = IDLE;
          to_hit  = 1'b1;
        end
      end
      S_WAIT: begin
        // Result is latched as modwait falls so it is already on
        // result_data during the CAPTURE cycle that pulses result_valid.
        if (!fir.modwait) begin
          state_d    = CAPTURE;
          res_data_d = fir.fir_out;
          res_err_d  = fir.err;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sdata_q    <= '0;
      coef_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      pending_q  <= 1'b0;
      rdy_q      <= 1'b0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < NUM_COEFF; i++) bank_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sdata_q    <= sdata_d;
      coef_q     <= coef_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      rdy_q      <= 1'b1;
      // A start that lands while a load is already pending is absorbed.
      pending_q  <= coeff_start | (pending_q & ~pend_clr);
      timeout_q  <= timeout_q | to_hit;
      if (coeff_wr && !pending_q) bank_q[coeff_idx] <= coeff_wdata;
    end
  end

  assign coeff_busy          = pending_q;
  assign fir.data_ready      = (state_q == S_REQ);
  assign fir.load_coeff      = (state_q == C_REQ);
  assign fir.sample_data     = sdata_q;
  assign fir.fir_coefficient = coef_q;
  assign result_valid        = (state_q == CAPTURE);
  assign result_data         = res_data_q;
  assign result_err          = res_err_q;
  assign timeout             = timeout_q;
endmodule
